// File: rtl/matriz_scan_ctrl_if.sv
// matriz_scan_ctrl_if: scan controller link to mode switches, row pattern registers and LED matrix
interface matriz_scan_ctrl_if;
  logic ch0;
  logic ch1;
  logic [4:0] row_data;
  logic [3:0] pat_idx;
  logic [6:0] acender_coluna;
  logic [4:0] saida_linha;
  logic frame_start;
  modport master(input ch0, ch1, row_data, output pat_idx, acender_coluna, saida_linha, frame_start);
  modport slave(output ch0, ch1, row_data, input pat_idx, acender_coluna, saida_linha, frame_start);
endinterface

// File: rtl/matriz_scan_ctrl.sv
// matriz_scan_ctrl: 5x7 matrix column scan, scroll offset and frame-aligned mode control
module matriz_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_CYC = 2,
  parameter int STEP_FRAMES = 25
) (
  input logic clk,
  input logic reset_n,
  matriz_scan_ctrl_if.master bus
);
  localparam int KW = $clog2(SCAN_DIV);
  localparam int FW = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
  logic [KW-1:0] k, k_n;
  logic [2:0] c, c_n;
  logic [FW-1:0] f, f_n;
  logic [3:0] off, off_n;
  logic [1:0] s1, mode_s, mode_q, mode_n;
  logic [4:0] row_q, row_n;
  logic run, slot_end, wrap, step, lit;
  // Outputs are registered from next-state so they always describe the slot the counters are in.
  always_comb begin
    slot_end = run && k == KW'(SCAN_DIV - 1);
    wrap = slot_end && c == 3'd6;
    step = wrap && f == FW'(STEP_FRAMES - 1);
    k_n = (!run || slot_end) ? '0 : k + 1'b1;
    c_n = !run ? '0 : slot_end ? (c == 3'd6 ? '0 : c + 1'b1) : c;
    f_n = wrap ? (step ? '0 : f + 1'b1) : f;
    mode_n = wrap ? mode_s : mode_q;
    off_n = mode_n == 2'b00 ? '0 : !step ? off : mode_n == 2'b01 ? off + 1'b1 : mode_n == 2'b10 ? off - 1'b1 : off;
    row_n = (run && k == KW'(BLANK_CYC - 1)) ? bus.row_data : row_q;
    lit = k_n >= KW'(BLANK_CYC) && mode_n != 2'b11;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run <= 1'b0;
      k <= '0;
      c <= '0;
      f <= '0;
      off <= '0;
      s1 <= '0;
      mode_s <= '0;
      mode_q <= '0;
      row_q <= '0;
      bus.pat_idx <= '0;
      bus.acender_coluna <= '0;
      bus.saida_linha <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      run <= 1'b1;
      k <= k_n;
      c <= c_n;
      f <= f_n;
      off <= off_n;
      s1 <= {bus.ch1, bus.ch0};
      mode_s <= s1;
      mode_q <= mode_n;
      row_q <= row_n;
      bus.pat_idx <= {1'b0, c_n} + off_n;
      bus.acender_coluna <= lit ? 7'b1000000 >> c_n : '0;
      bus.saida_linha <= lit ? row_n : '0;
      bus.frame_start <= k_n == '0 && c_n == '0;
    end
  end
endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// tb_matriz_scan_ctrl: scoreboard bench for the matrix scan controller with a frame-level reference model
module tb_matriz_scan_ctrl;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int SF = 2;
  localparam int FL = SD * 7;
  typedef struct packed {
    logic [3:0] pat;
    logic [6:0] acen;
    logic [4:0] row;
    logic fs;
  } obs_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  matriz_scan_ctrl_if bus();
  matriz_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .STEP_FRAMES(SF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] patt(input logic [3:0] p);
    return 5'b10101 ^ {p, 1'b0};
  endfunction
  assign bus.row_data = patt(bus.pat_idx);
  obs_t sb[$];
  obs_t got, exp_v;
  int n, bf;
  int checks = 0;
  int fails = 0;
  logic [1:0] bm;
  logic [3:0] boff;
  function automatic obs_t model();
    obs_t e;
    int k, c;
    k = n % SD;
    c = (n / SD) % 7;
    e.pat = 4'((c + int'(boff)) % 16);
    e.acen = (k < BC || bm == 2'b11) ? 7'd0 : 7'(64 >> c);
    e.row = e.acen != 7'd0 ? patt(e.pat) : 5'd0;
    e.fs = n % FL == 0;
    return e;
  endfunction
  task automatic cycle();
    logic step;
    @(posedge clk);
    sb.push_back(model());
    @(negedge clk);
    got = {bus.pat_idx, bus.acender_coluna, bus.saida_linha, bus.frame_start};
    if (n % SD == SD - 1 && (n / SD) % 7 == 6) begin
      step = bf == SF - 1;
      bm = {bus.ch1, bus.ch0};
      bf = step ? 0 : bf + 1;
      boff = bm == 2'b00 ? 4'd0 : !step ? boff : bm == 2'b01 ? boff + 4'd1 : bm == 2'b10 ? boff - 4'd1 : boff;
    end
    n++;
  endtask
  task automatic restart(input logic [1:0] m);
    {bus.ch1, bus.ch0} = m;
    n = 0;
    bf = 0;
    bm = 2'b00;
    boff = 4'd0;
    sb.delete();
    reset_n = 1'b1;
  endtask
  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    {bus.ch1, bus.ch0} = 2'b11;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.pat_idx, bus.acender_coluna, bus.saida_linha, bus.frame_start} !== 17'd0) begin
        fails++;
        $display("FAIL reset got=%h want=0", {bus.pat_idx, bus.acender_coluna, bus.saida_linha, bus.frame_start});
      end
    end
  endtask
  task automatic test_frame_timing();
    int starts;
    starts = 0;
    restart(2'b00);
    repeat (2 * FL) begin
      cycle();
      exp_v = sb.pop_front();
      starts += int'(got.fs);
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL frame_timing n=%0d got pat=%h col=%b row=%b fs=%b want pat=%h col=%b row=%b fs=%b",
                 n - 1, got.pat, got.acen, got.row, got.fs, exp_v.pat, exp_v.acen, exp_v.row, exp_v.fs);
      end
    end
    checks++;
    if (starts != 2) begin
      fails++;
      $display("FAIL frame_start_count got=%0d want=2", starts);
    end
  endtask
  task automatic test_scroll(input logic [1:0] m, input int frames);
    hold_reset();
    restart(m);
    repeat (frames * FL) begin
      cycle();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL scroll_%0d n=%0d got pat=%h col=%b row=%b fs=%b want pat=%h col=%b row=%b fs=%b",
                 m, n - 1, got.pat, got.acen, got.row, got.fs, exp_v.pat, exp_v.acen, exp_v.row, exp_v.fs);
      end
    end
  endtask
  task automatic test_mode_change();
    hold_reset();
    restart(2'b01);
    for (int i = 0; i < 8 * FL; i++) begin
      if (i == 3 * FL + 3 * SD) {bus.ch1, bus.ch0} = 2'b11;
      if (i == 6 * FL + 3 * SD) {bus.ch1, bus.ch0} = 2'b00;
      cycle();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL mode_change n=%0d got pat=%h col=%b row=%b fs=%b want pat=%h col=%b row=%b fs=%b",
                 n - 1, got.pat, got.acen, got.row, got.fs, exp_v.pat, exp_v.acen, exp_v.row, exp_v.fs);
      end
    end
  endtask
  task automatic test_reset_mid();
    hold_reset();
    restart(2'b01);
    repeat (10 * FL + 4 * SD + 3) begin
      cycle();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL pre_reset n=%0d got=%h want=%h", n - 1, got, exp_v);
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pat_idx, bus.acender_coluna, bus.saida_linha, bus.frame_start} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid got=%h want=0", {bus.pat_idx, bus.acender_coluna, bus.saida_linha, bus.frame_start});
    end
    restart(2'b00);
    repeat (2 * FL) begin
      cycle();
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL restart n=%0d got=%h want=%h", n - 1, got, exp_v);
      end
    end
  endtask
  initial begin
    {bus.ch1, bus.ch0} = 2'b00;
    test_reset();
    test_frame_timing();
    test_scroll(2'b01, 33);
    test_scroll(2'b10, 5);
    test_mode_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/matriz_scan_ctrl.md
Name: matriz_scan_ctrl

Overview:
- Sequencer for the 5x7 LED matrix datapath: column-scan timing, scroll offset and mode control.
- Generates the one-hot column enable, computes which of the 16 pattern columns feeds each physical column, and samples the 5-bit row word returned by the row pattern registers.
- Applies anti-ghost blanking between column slots and mode changes from ch0/ch1 only at frame boundaries.
- Sits between the top level and the row pattern registers; replaces free-running column counting.

Parameters:
- SCAN_DIV, 1000: clocks per column slot; must be > BLANK_CYC.
- BLANK_CYC, 2: cycles at the start of each slot with all outputs forced to 0; must be ≥ 1.
- STEP_FRAMES, 25: full frames (7 slots each) per scroll step.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- ch0  in  1  mode select bit 0, asynchronous switch input.
- ch1  in  1  mode select bit 1, asynchronous switch input.
- row_data  in  5  row bits for pattern column pat_idx, from the row pattern registers; bit 0 = row 1.
- pat_idx  out  4  pattern column currently addressed, 0..15.
- acender_coluna  out  7  one-hot column enable, active high; bit 6 = leftmost column (c=0).
- saida_linha  out  5  row drive for the lit column, active high.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame (slot c=0, k=0).

Behaviour:
- Reset (reset_n=0 at a clk edge) clears:
  - prescaler k, column index c, frame counter f, offset, mode_q, both sync stages, and the row register.
  - All outputs read 0, including pat_idx=0 and frame_start=0.
- Reset held mid-frame aborts immediately; no partial state survives.
- The first cycle after reset release is slot c=0, k=0, with frame_start=1.
- Input sync: ch1:ch0 passes through two flops to give mode_s, 2-cycle latency. Modes:
  - 00 static: offset forced to 0.
  - 01 scroll left: offset+1 mod 16 per step.
  - 10 scroll right: offset−1 mod 16 per step.
  - 11 blank: scanning continues, outputs held at 0, offset frozen.
- mode_q loads mode_s only on the frame-wrap event (c=6, k=SCAN_DIV−1). If the new mode is 00, offset clears in the same edge.
- Slot timing:
  - k counts 0..SCAN_DIV−1, then wraps to 0 and c advances; c wraps 6→0, which is a frame wrap.
  - Frame wrap increments f. When f=STEP_FRAMES−1, f wraps to 0 and a scroll step is applied to offset per mode_q.
  - A mode load and a scroll step on the same edge: the step uses the new mode_q.
- pat_idx = (c + offset) mod 16, valid throughout the slot; the 4-bit add wraps naturally.
- The row register samples row_data on the edge ending cycle k=BLANK_CYC−1, so row_data must be stable for k<BLANK_CYC. It holds for the rest of the slot.
- Outputs at slot cycle k:
  - k<BLANK_CYC, or mode_q=11: acender_coluna=0 and saida_linha=0.
  - Otherwise: acender_coluna has only bit (6−c) set, and saida_linha = the row register.
- Outputs are register-driven (glitch-free).
- Never more than one acender_coluna bit set. saida_linha is nonzero only when acender_coluna is nonzero.
- An offset change takes effect from the next slot's pat_idx; it is never applied mid-slot.

Test Plan:
- Reset and frame timing, with SCAN_DIV=4, BLANK_CYC=1, STEP_FRAMES=2, mode 00:
  - Release reset → frame_start pulses at cycles 0 and 28.
  - acender_coluna = 0, 1000000, 1000000, 1000000, 0, 0100000, …
  - pat_idx steps 0..6 per slot.
- Row path: row_data = pat_idx-dependent pattern (5'b10101 when pat_idx=0), mode 00 → saida_linha = 10101 for slot c=0, cycles k=1..3; 0 at k=0.
- Scroll left, mode 01 from reset:
  - Offset steps 0→1 after frame 2, so pat_idx in slot c=0 of frame 3 = 1.
  - After 32 frames offset is back to 0; c=6 with offset=15 gives pat_idx=5.
- Scroll right: mode 10 → offset 0→15→14 at successive steps; pat_idx at c=0 = 15, then 14.
- Mode change mid-frame: switch 01→11 at slot c=3 → outputs keep scanning until the frame wrap, then all-zero for whole frames. Switching back to 00 → offset=0 from the next frame.
- Reset mid-operation: assert reset_n=0 for 1 cycle at c=4, k=2, mode 01, offset=5 → next cycle all outputs are 0 and offset=0. Restart matches the first scenario exactly.
